// File: rtl/e1_vec_pkg.sv
// Shared types and the stimulus table for the e1 vector checker.
package e1_vec_pkg;

  typedef struct packed {
    logic [2:0] a;
    logic [3:0] b;
    logic       exp_x;
    logic [2:0] exp_y;
    logic       chk_y;
  } vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  // Entries 7..15 are unused and read back as all-zero.
  localparam vec_t E1_VECS [16] = '{
    '{3'd1, 4'd1, 1'b0, 3'd3, 1'b1},
    '{3'd1, 4'd3, 1'b0, 3'd0, 1'b0},
    '{3'd7, 4'd2, 1'b1, 3'd2, 1'b1},
    '{3'd4, 4'd1, 1'b0, 3'd2, 1'b1},
    '{3'd6, 4'd1, 1'b0, 3'd2, 1'b1},
    '{3'd4, 4'd4, 1'b1, 3'd0, 1'b1},
    '{3'd6, 4'd4, 1'b1, 3'd0, 1'b1},
    '0, '0, '0, '0, '0, '0, '0, '0, '0
  };

  function automatic logic vec_mismatch(input vec_t v, input logic x, input logic [2:0] y);
    return (x != v.exp_x) | (v.chk_y & (y != v.exp_y));
  endfunction

endpackage

// File: rtl/e1_vec_rom.sv
// Combinational index -> vector lookup into the e1 stimulus table.
module e1_vec_rom
  import e1_vec_pkg::*;
(
  input  logic [3:0]               idx_i,
  output logic [$bits(vec_t)-1:0]  vec_o
);

  assign vec_o = E1_VECS[idx_i];

endmodule

// File: rtl/e1_vector_checker.sv
// Self-checking driver for the e1 truth-table block: drives each table vector,
// waits SETTLE cycles, compares x/y and accumulates a saturating fail count.
// Optional first-failure log enabled by defining E1_VEC_FAILLOG_EN.
module e1_vector_checker
  import e1_vec_pkg::*;
#(
  parameter int unsigned N_VEC  = 7,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [2:0]       a_o,
  output logic [3:0]       b_o,
  input  logic             x_i,
  input  logic [2:0]       y_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       vec_idx
`ifdef E1_VEC_FAILLOG_EN
  ,
  output logic             ff_valid,
  output logic [3:0]       ff_idx,
  output logic             ff_x,
  output logic [2:0]       ff_y
`endif
);

  state_t                  state_q;
  logic [3:0]              vec_idx_q;
  logic [3:0]              cnt_q;
  logic [2:0]              a_q;
  logic [3:0]              b_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [CNT_W-1:0]        fail_cnt_q;
  logic [CNT_W-1:0]        fail_cnt_d;
  logic [$bits(vec_t)-1:0] rom_data;
  vec_t                    cur_vec;
  logic                    mismatch;
  logic                    last_vec;

`ifdef E1_VEC_FAILLOG_EN
  logic                    ff_valid_q;
  logic [3:0]              ff_idx_q;
  logic                    ff_x_q;
  logic [2:0]              ff_y_q;
`endif

  e1_vec_rom u_rom (
    .idx_i (vec_idx_q),
    .vec_o (rom_data)
  );

  always_comb begin
    cur_vec    = vec_t'(rom_data);
    mismatch   = vec_mismatch(cur_vec, x_i, y_i);
    last_vec   = (vec_idx_q == 4'(N_VEC - 1));
    fail_cnt_d = fail_cnt_q;
    if (mismatch && (fail_cnt_q != '1)) begin
      fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      vec_idx_q  <= '0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
`ifdef E1_VEC_FAILLOG_EN
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      ff_x_q     <= 1'b0;
      ff_y_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_DRIVE;
            vec_idx_q  <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
`ifdef E1_VEC_FAILLOG_EN
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_x_q     <= 1'b0;
            ff_y_q     <= '0;
`endif
          end
        end
        S_DRIVE: begin
          a_q     <= cur_vec.a;
          b_q     <= cur_vec.b;
          cnt_q   <= 4'(SETTLE);
          state_q <= (SETTLE == 0) ? S_CHECK : S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          fail_cnt_q <= fail_cnt_d;
`ifdef E1_VEC_FAILLOG_EN
          if (mismatch && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_idx_q   <= vec_idx_q;
            ff_x_q     <= x_i;
            ff_y_q     <= y_i;
          end
`endif
          // pass reflects this final compare, hence fail_cnt_d rather than _q
          if (last_vec) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (fail_cnt_d == '0);
          end else begin
            vec_idx_q <= vec_idx_q + 4'd1;
            state_q   <= S_DRIVE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_o      = a_q;
  assign b_o      = b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_cnt = fail_cnt_q;
  assign vec_idx  = vec_idx_q;

`ifdef E1_VEC_FAILLOG_EN
  assign ff_valid = ff_valid_q;
  assign ff_idx   = ff_idx_q;
  assign ff_x     = ff_x_q;
  assign ff_y     = ff_y_q;
`endif

endmodule

// File: tb/tb_e1_vector_checker.sv
// Directed bench for e1_vector_checker against a behavioural truth-table model
// with an optional stuck-y fault; three configurations share clock and reset.
module tb_e1_vector_checker;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   n;

  logic [2:0] exp_a [7] = '{3'd1, 3'd1, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
  logic [3:0] exp_b [7] = '{4'd1, 4'd3, 4'd2, 4'd1, 4'd1, 4'd4, 4'd4};

  // Correct e1 truth table for the listed inputs; fault forces y=1 everywhere.
  function automatic logic [3:0] tt(input logic [2:0] a, input logic [3:0] b, input logic fault);
    logic [3:0] r;
    case ({a, b})
      {3'd1, 4'd1}: r = {1'b0, 3'd3};
      {3'd1, 4'd3}: r = {1'b0, 3'd5};
      {3'd7, 4'd2}: r = {1'b1, 3'd2};
      {3'd4, 4'd1}: r = {1'b0, 3'd2};
      {3'd6, 4'd1}: r = {1'b0, 3'd2};
      {3'd4, 4'd4}: r = {1'b1, 3'd0};
      {3'd6, 4'd4}: r = {1'b1, 3'd0};
      default:      r = 4'd0;
    endcase
    if (fault) r[2:0] = 3'd1;
    return r;
  endfunction

  // Instance A: defaults (N_VEC=7, SETTLE=1, CNT_W=4)
  logic       start_a, fault_a, x_a, busy_a, done_a, pass_a;
  logic [2:0] a_a, y_a;
  logic [3:0] b_a, fc_a, idx_a;
`ifdef E1_VEC_FAILLOG_EN
  logic       ffv_a, ffx_a;
  logic [3:0] ffi_a;
  logic [2:0] ffy_a;
`endif
  assign {x_a, y_a} = tt(a_a, b_a, fault_a);

  e1_vector_checker #(.N_VEC(7), .SETTLE(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .a_o(a_a), .b_o(b_a),
    .x_i(x_a), .y_i(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_cnt(fc_a), .vec_idx(idx_a)
`ifdef E1_VEC_FAILLOG_EN
    , .ff_valid(ffv_a), .ff_idx(ffi_a), .ff_x(ffx_a), .ff_y(ffy_a)
`endif
  );

  // Instance B: SETTLE=2, 2-bit counter to exercise saturation
  logic       start_b, fault_b, x_b, busy_b, done_b, pass_b;
  logic [2:0] a_b, y_b;
  logic [3:0] b_b, idx_b;
  logic [1:0] fc_b;
`ifdef E1_VEC_FAILLOG_EN
  logic       ffv_b, ffx_b;
  logic [3:0] ffi_b;
  logic [2:0] ffy_b;
`endif
  assign {x_b, y_b} = tt(a_b, b_b, fault_b);

  e1_vector_checker #(.N_VEC(7), .SETTLE(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .a_o(a_b), .b_o(b_b),
    .x_i(x_b), .y_i(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_cnt(fc_b), .vec_idx(idx_b)
`ifdef E1_VEC_FAILLOG_EN
    , .ff_valid(ffv_b), .ff_idx(ffi_b), .ff_x(ffx_b), .ff_y(ffy_b)
`endif
  );

  // Instance C: single vector, no settle
  logic       start_c, fault_c, x_c, busy_c, done_c, pass_c;
  logic [2:0] a_c, y_c;
  logic [3:0] b_c, fc_c, idx_c;
`ifdef E1_VEC_FAILLOG_EN
  logic       ffv_c, ffx_c;
  logic [3:0] ffi_c;
  logic [2:0] ffy_c;
`endif
  assign {x_c, y_c} = tt(a_c, b_c, fault_c);

  e1_vector_checker #(.N_VEC(1), .SETTLE(0), .CNT_W(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .a_o(a_c), .b_o(b_c),
    .x_i(x_c), .y_i(y_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .fail_cnt(fc_c), .vec_idx(idx_c)
`ifdef E1_VEC_FAILLOG_EN
    , .ff_valid(ffv_c), .ff_idx(ffi_c), .ff_x(ffx_c), .ff_y(ffy_c)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({busy_a, done_a, pass_a, fc_a, idx_a, a_a, b_a} !== 18'd0) begin
      fails++;
      $display("FAIL reset_a: got busy/done/pass/fc/idx/a/b=%b want all zero",
               {busy_a, done_a, pass_a, fc_a, idx_a, a_a, b_a});
    end
`ifdef E1_VEC_FAILLOG_EN
    tests++;
    if ({ffv_a, ffi_a, ffx_a, ffy_a} !== 9'd0) begin
      fails++;
      $display("FAIL reset_ff: got %b want 0", {ffv_a, ffi_a, ffx_a, ffy_a});
    end
`endif
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_correct_run();
    int k;
    fault_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      if (n % 3 == 2) begin
        k = (n - 2) / 3;
        tests++;
        if ({a_a, b_a, idx_a} !== {exp_a[k], exp_b[k], 4'(k)}) begin
          fails++;
          $display("FAIL drive_vec%0d: got a=%0d b=%0d idx=%0d want a=%0d b=%0d idx=%0d",
                   k, a_a, b_a, idx_a, exp_a[k], exp_b[k], k);
        end
      end
      tick();
    end
    tests++;
    if (n != 21) begin
      fails++;
      $display("FAIL run_len_ok: got %0d want 21", n);
    end
    tests++;
    if ({busy_a, done_a, pass_a, fc_a} !== {3'b011, 4'd0}) begin
      fails++;
      $display("FAIL result_ok: got busy/done/pass=%b fc=%0d want 011 fc=0",
               {busy_a, done_a, pass_a}, fc_a);
    end
    tests++;
    if ({a_a, b_a} !== {3'd6, 4'd4}) begin
      fails++;
      $display("FAIL hold_last: got a=%0d b=%0d want a=6 b=4", a_a, b_a);
    end
  endtask

  task automatic test_faulty_dut();
    fault_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      tick();
    end
    tests++;
    if (n != 21) begin
      fails++;
      $display("FAIL run_len_fault: got %0d want 21", n);
    end
    tests++;
    if ({done_a, pass_a, fc_a} !== {2'b10, 4'd6}) begin
      fails++;
      $display("FAIL result_fault: got done=%b pass=%b fc=%0d want done=1 pass=0 fc=6",
               done_a, pass_a, fc_a);
    end
`ifdef E1_VEC_FAILLOG_EN
    tests++;
    if ({ffv_a, ffi_a, ffx_a, ffy_a} !== {1'b1, 4'd0, 1'b0, 3'd1}) begin
      fails++;
      $display("FAIL faillog: got valid=%b idx=%0d x=%b y=%0d want 1 0 0 1",
               ffv_a, ffi_a, ffx_a, ffy_a);
    end
`endif
  endtask

  task automatic test_start_while_busy();
    fault_a = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      start_a = (n == 10) || (n == 21);
      tick();
    end
    start_a = 1'b0;
    tests++;
    if (n != 21) begin
      fails++;
      $display("FAIL run_len_ignore: got %0d want 21", n);
    end
    tick();
    tests++;
    if ({busy_a, done_a, pass_a, fc_a, idx_a} !== {3'b011, 4'd0, 4'd6}) begin
      fails++;
      $display("FAIL start_at_done_entry: got busy/done/pass=%b fc=%0d idx=%0d want 011 0 6",
               {busy_a, done_a, pass_a}, fc_a, idx_a);
    end
`ifdef E1_VEC_FAILLOG_EN
    tests++;
    if (ffv_a !== 1'b0) begin
      fails++;
      $display("FAIL faillog_clear: got valid=%b want 0", ffv_a);
    end
`endif
  endtask

  task automatic test_reset_midrun();
    fault_a = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (busy_a && n < 13) begin
      n++;
      tick();
    end
    tests++;
    if ({busy_a, fc_a, idx_a} !== {1'b1, 4'd3, 4'd4}) begin
      fails++;
      $display("FAIL pre_reset: got busy=%b fc=%0d idx=%0d want 1 3 4", busy_a, fc_a, idx_a);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy_a, done_a, pass_a, fc_a, idx_a, a_a, b_a} !== 18'd0) begin
      fails++;
      $display("FAIL async_reset: got %b want all zero",
               {busy_a, done_a, pass_a, fc_a, idx_a, a_a, b_a});
    end
    rst_n = 1'b1;
    fault_a = 1'b0;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    n = 0;
    while (busy_a && n < 100) begin
      n++;
      tick();
    end
    tests++;
    if ({n[7:0], done_a, pass_a, fc_a} !== {8'd21, 2'b11, 4'd0}) begin
      fails++;
      $display("FAIL post_reset_run: got len=%0d done=%b pass=%b fc=%0d want 21 1 1 0",
               n, done_a, pass_a, fc_a);
    end
  endtask

  task automatic test_saturation();
    fault_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    n = 0;
    while (busy_b && n < 100) begin
      n++;
      tick();
    end
    tests++;
    if (n != 28) begin
      fails++;
      $display("FAIL run_len_settle2: got %0d want 28", n);
    end
    tests++;
    if ({done_b, pass_b, fc_b} !== {2'b10, 2'd3}) begin
      fails++;
      $display("FAIL saturate: got done=%b pass=%b fc=%0d want 1 0 3", done_b, pass_b, fc_b);
    end
  endtask

  task automatic test_restart_from_done();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tests++;
    if ({busy_b, done_b, pass_b, fc_b, idx_b} !== {3'b100, 2'd0, 4'd0}) begin
      fails++;
      $display("FAIL restart: got busy/done/pass=%b fc=%0d idx=%0d want 100 0 0",
               {busy_b, done_b, pass_b}, fc_b, idx_b);
    end
    n = 0;
    while (busy_b && n < 100) begin
      n++;
      tick();
    end
    tests++;
    if ({n[7:0], done_b, fc_b} !== {8'd28, 1'b1, 2'd3}) begin
      fails++;
      $display("FAIL restart_run: got len=%0d done=%b fc=%0d want 28 1 3", n, done_b, fc_b);
    end
  endtask

  task automatic test_single_vector();
    fault_c = 1'b0;
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    n = 0;
    while (busy_c && n < 100) begin
      n++;
      tick();
    end
    tests++;
    if (n != 2) begin
      fails++;
      $display("FAIL run_len_single: got %0d want 2", n);
    end
    tests++;
    if ({busy_c, done_c, pass_c, fc_c, idx_c, a_c, b_c} !== {3'b011, 4'd0, 4'd0, 3'd1, 4'd1}) begin
      fails++;
      $display("FAIL single_result: got busy/done/pass=%b fc=%0d idx=%0d a=%0d b=%0d want 011 0 0 1 1",
               {busy_c, done_c, pass_c}, fc_c, idx_c, a_c, b_c);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    fault_a = 1'b0;
    fault_b = 1'b0;
    fault_c = 1'b0;
    test_reset();
    test_correct_run();
    test_faulty_dut();
    test_start_while_busy();
    test_reset_midrun();
    test_saturation();
    test_restart_from_done();
    test_single_vector();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
